// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2,
    RELOCK    = 2'd3
  } state_t;

  localparam int unsigned DEF_LOCK_FILTER  = 16;
  localparam int unsigned DEF_RESET_HOLD   = 64;
  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned DEF_TIMEOUT      = 1000000;
  localparam int unsigned DEF_RELOCK_PULSE = 4;

  // Bits needed to hold the values 0..n
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser for an asynchronous level flag, synchronous active-high reset.
module lock_sync (
  input  logic clock_in,
  input  logic rst_in,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Double-register the flag into the clock_in domain
  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL lock consumer: filters the lock flag, stretches a synchronous system
// reset, raises ready in RUN and counts lock losses.
// Define PLL_RESET_WATCHDOG_EN to build the relock watchdog (RELOCK state,
// relock_req pulses); without it relock_req is tied low.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int unsigned LOCK_FILTER  = DEF_LOCK_FILTER,
  parameter int unsigned RESET_HOLD   = DEF_RESET_HOLD,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned RELOCK_PULSE = DEF_RELOCK_PULSE
) (
  input  logic             clock_in,
  input  logic             rst_in,
  input  logic             locked_in,
  output logic             rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] loss_cnt,
  output logic             relock_req
);

  localparam int unsigned FILT_W = cnt_width(LOCK_FILTER);
  localparam int unsigned HOLD_W = cnt_width(RESET_HOLD);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]  LOSS_MAX  = '1;

  logic              lk;
  logic [FILT_W-1:0] filt;
  logic [HOLD_W-1:0] hold;
  state_t            state;
  state_t            state_nxt_c;
  logic              filt_done_c;
  logic              hold_done_c;
  logic              wd_fire_c;
  logic              pulse_done_c;

  lock_sync u_lock_sync (
    .clock_in (clock_in),
    .rst_in   (rst_in),
    .async_in (locked_in),
    .sync_out (lk)
  );

  // Transition rules; a lock drop always beats a terminal count
  function automatic state_t next_state(
    input state_t cur,
    input logic   lk_i,
    input logic   filt_done,
    input logic   hold_done,
    input logic   wd_fire,
    input logic   pulse_done
  );
    state_t nxt;
    nxt = cur;
    case (cur)
      WAIT_LOCK: begin
        if (lk_i && filt_done) nxt = HOLD;
        else if (wd_fire)      nxt = RELOCK;
      end
      HOLD: begin
        if (!lk_i)          nxt = WAIT_LOCK;
        else if (hold_done) nxt = RUN;
      end
      RUN: begin
        if (!lk_i) nxt = WAIT_LOCK;
      end
      RELOCK: begin
        if (pulse_done) nxt = WAIT_LOCK;
      end
      default: nxt = WAIT_LOCK;
    endcase
    return nxt;
  endfunction

  assign filt_done_c = (filt == FILT_LAST);
  assign hold_done_c = (hold == HOLD_LAST);
  assign state_nxt_c = next_state(state, lk, filt_done_c, hold_done_c,
                                  wd_fire_c, pulse_done_c);

  // Sequencer FSM, phase counters and outputs decoded from the next state
  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      state    <= WAIT_LOCK;
      filt     <= '0;
      hold     <= '0;
      loss_cnt <= '0;
      rst_out  <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state   <= state_nxt_c;
      rst_out <= (state_nxt_c != RUN);
      ready   <= (state_nxt_c == RUN);

      if (state == WAIT_LOCK && state_nxt_c == WAIT_LOCK && lk) filt <= filt + FILT_W'(1);
      else                                                      filt <= '0;

      if (state == HOLD && state_nxt_c == HOLD) hold <= hold + HOLD_W'(1);
      else                                      hold <= '0;

      if (state == RUN && state_nxt_c == WAIT_LOCK && loss_cnt != LOSS_MAX)
        loss_cnt <= loss_cnt + CNT_W'(1);
    end
  end

`ifdef PLL_RESET_WATCHDOG_EN
  localparam int unsigned TMR_W = cnt_width(TIMEOUT);
  localparam int unsigned PLS_W = cnt_width(RELOCK_PULSE);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(RELOCK_PULSE - 1);

  logic [TMR_W-1:0] tmr;
  logic [PLS_W-1:0] pls;

  assign wd_fire_c    = (tmr == TMR_LAST);
  assign pulse_done_c = (pls == PLS_LAST);

  // Lock timeout while waiting, and relock pulse width while relocking
  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      tmr        <= '0;
      pls        <= '0;
      relock_req <= 1'b0;
    end else begin
      relock_req <= (state_nxt_c == RELOCK);

      if (state == WAIT_LOCK && state_nxt_c == WAIT_LOCK) tmr <= tmr + TMR_W'(1);
      else                                                tmr <= '0;

      if (state == RELOCK && state_nxt_c == RELOCK) pls <= pls + PLS_W'(1);
      else                                          pls <= '0;
    end
  end
`else
  // No watchdog: WAIT_LOCK waits forever and RELOCK is unreachable
  logic unused_wd_params;
  assign unused_wd_params = ^{TIMEOUT, RELOCK_PULSE};
  assign wd_fire_c        = 1'b0;
  assign pulse_done_c     = 1'b1;
  assign relock_req       = 1'b0;
`endif

endmodule
